fb_write_sched: RTL and testbench

Frame-buffer write scheduler for the 800x600, 6-bit-colour block memory (write port A). It sequences full raster refill sweeps, driving scan coordinates to the colour generator and aligning its registered colour output with the write address. Between sweeps it shares port A with a single-pixel write requester. It sits between the game/snake logic (sweep triggers, pixel writes) and the dual-port frame-buffer RAM, whose port B stays with the VGA output.

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_write_sched_if.sv | 15 +
 rtl/fb_align_pipe.sv | 54 +++++
 rtl/fb_write_sched.sv | 160 ++++++++++++++++
 tb/tb_fb_write_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the frame-buffer write scheduler.
package fb_pkg;

    localparam int FB_WIDTH  = 800;
    localparam int FB_HEIGHT = 600;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 6;
    localparam int SCAN_W    = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        PIXEL = 2'd3
    } fb_state_e;

endpackage

// File: rtl/fb_write_sched_if.sv
// Single-pixel write request channel between the game logic and the scheduler.
interface fb_write_sched_if;
    import fb_pkg::*;

    // px_req is raised with px_addr/px_data stable and held until a one-cycle
    // px_ack; the request is consumed on the cycle px_ack is high.
    logic              px_req;
    logic [ADDR_W-1:0] px_addr;
    logic [DATA_W-1:0] px_data;
    logic              px_ack;

    modport master (output px_req, output px_addr, output px_data, input px_ack);
    modport slave  (input px_req, input px_addr, input px_data, output px_ack);

endinterface

// File: rtl/fb_align_pipe.sv
// DEPTH-stage delay of {valid, addr} that lines sweep addresses up with the
// colour generator output; the final write enable also folds in the gate.
module fb_align_pipe
    import fb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              gate,
    output logic              out_valid,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  v_q;
    logic [ADDR_W-1:0] a_q [DEPTH];
    logic              wen_q;

    logic [DEPTH:0]    v_chain;
    logic [ADDR_W-1:0] a_chain [DEPTH+1];

    always_comb begin
        v_chain    = {v_q, in_valid};
        a_chain[0] = in_addr;
        for (int i = 0; i < DEPTH; i++) begin
            a_chain[i+1] = a_q[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            v_q   <= '0;
            wen_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                v_q[i] <= v_chain[i];
                a_q[i] <= a_chain[i];
            end
            // Gate is sampled on the edge that launches the write.
            wen_q <= v_chain[DEPTH-1] & gate;
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_wen   = wen_q;
    assign out_addr  = a_q[DEPTH-1];

endmodule

// File: rtl/fb_write_sched.sv
// Frame-buffer port A scheduler: full raster refill sweeps with colour
// alignment, interleaved with single-pixel writes while idle.
module fb_write_sched
    import fb_pkg::*;
#(
    parameter int WIDTH     = FB_WIDTH,
    parameter int HEIGHT    = FB_HEIGHT,
    parameter int COLOR_LAT = 1
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              frame_req,
    input  logic              enable,
    fb_write_sched_if.slave   px,
    output logic [SCAN_W-1:0] scan_x,
    output logic [SCAN_W-1:0] scan_y,
    input  logic [DATA_W-1:0] color_in,
    output logic              fb_wen,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_din,
    output logic              busy,
    output logic              frame_done,
    output fb_state_e         state_dbg
);

    localparam logic [SCAN_W-1:0] X_LAST = SCAN_W'(WIDTH - 1);
    localparam logic [SCAN_W-1:0] Y_LAST = SCAN_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] PIX_N  = ADDR_W'(WIDTH * HEIGHT);
    localparam int                DRW    = (COLOR_LAT > 1) ? $clog2(COLOR_LAT) : 1;
    localparam logic [DRW-1:0]    DR_LAST = DRW'(COLOR_LAT - 1);

    fb_state_e         state_q, state_d;
    logic              pending_q, pending_d;
    logic [SCAN_W-1:0] x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              issue_q, issue_d;
    logic [DRW-1:0]    drain_q, drain_d;
    logic [ADDR_W-1:0] pxa_q, pxa_d;
    logic [DATA_W-1:0] pxd_q, pxd_d;
    logic              px_wen_q, px_wen_d;
    logic              done_q, done_d;

    logic              slot_valid, slot_wen;
    logic [ADDR_W-1:0] slot_addr;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            issue_q   <= 1'b0;
            drain_q   <= '0;
            pxa_q     <= '0;
            pxd_q     <= '0;
            px_wen_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            issue_q   <= issue_d;
            drain_q   <= drain_d;
            pxa_q     <= pxa_d;
            pxd_q     <= pxd_d;
            px_wen_q  <= px_wen_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        issue_d   = 1'b0;
        drain_d   = drain_q;
        pxa_d     = pxa_q;
        pxd_d     = pxd_q;
        px_wen_d  = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_req || pending_q) begin
                    state_d   = SWEEP;
                    pending_d = 1'b0;
                    x_d       = '0;
                    y_d       = '0;
                    addr_d    = '0;
                    issue_d   = 1'b1;
                end else if (px.px_req) begin
                    state_d  = PIXEL;
                    pxa_d    = px.px_addr;
                    pxd_d    = px.px_data;
                    px_wen_d = enable && (px.px_addr < PIX_N);
                end
            end
            SWEEP: begin
                pending_d = pending_q | frame_req;
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    // Address is a running count, so y*WIDTH+x needs no multiplier.
                    issue_d = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                pending_d = pending_q | frame_req;
                if (drain_q == DR_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            PIXEL: begin
                pending_d = pending_q | frame_req;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    fb_align_pipe #(.DEPTH(COLOR_LAT)) u_align (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (issue_q),
        .in_addr   (addr_q),
        .gate      (enable),
        .out_valid (slot_valid),
        .out_wen   (slot_wen),
        .out_addr  (slot_addr)
    );

    assign scan_x     = x_q;
    assign scan_y     = y_q;
    assign busy       = (state_q == SWEEP) || (state_q == DRAIN);
    assign frame_done = done_q;
    assign state_dbg  = state_q;
    assign px.px_ack  = (state_q == PIXEL);

    // The pipe is empty before PIXEL can be entered, so the two write sources
    // never overlap. color_in comes straight from the generator's own register.
    assign fb_wen  = slot_wen | px_wen_q;
    assign fb_addr = (state_q == PIXEL) ? pxa_q : (slot_valid ? slot_addr : '0);
    assign fb_din  = (state_q == PIXEL) ? pxd_q : (slot_valid ? color_in : '0);

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched on a reduced raster, checked cycle by cycle
// against a schedule model built from sweep start times and pixel grants.
module tb_fb_write_sched;
    import fb_pkg::*;

    localparam int W   = 12;
    localparam int H   = 5;
    localparam int N   = W * H;
    localparam int LAT = 2;
    localparam int FAR = -100000;

    // ---------------- clock / reset / DUT ----------------
    logic CLK;
    logic rst_n, frame_req, enable;
    logic [SCAN_W-1:0] scan_x, scan_y;
    logic [DATA_W-1:0] color_in;
    logic fb_wen, busy, frame_done;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_din;
    fb_state_e state_dbg;

    fb_write_sched_if pif();

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    fb_write_sched #(.WIDTH(W), .HEIGHT(H), .COLOR_LAT(LAT)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .frame_req  (frame_req),
        .enable     (enable),
        .px         (pif.slave),
        .scan_x     (scan_x),
        .scan_y     (scan_y),
        .color_in   (color_in),
        .fb_wen     (fb_wen),
        .fb_addr    (fb_addr),
        .fb_din     (fb_din),
        .busy       (busy),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // Colour generator: LAT registers deep, colour = (x+y) mod 64.
    logic [DATA_W-1:0] gen_q [LAT];
    always @(posedge CLK) begin
        gen_q[0] <= DATA_W'(scan_x + scan_y);
        for (int i = 1; i < LAT; i++) gen_q[i] <= gen_q[i-1];
    end
    assign color_in = gen_q[LAT-1];

    // ---------------- reference model ----------------
    int edge_n = 0;
    int sw_start = FAR;
    int px_e = FAR;
    bit pend = 1'b0;
    logic [ADDR_W-1:0] pxa_m;
    logic [DATA_W-1:0] pxd_m;
    logic pxw_m;
    logic [ADDR_W-1:0] exp_q[$];

    logic [SCAN_W-1:0] x_e, y_e;
    logic w_e, b_e, dn_e, ack_e;
    logic [ADDR_W-1:0] a_e;
    logic [DATA_W-1:0] d_e;
    int st_e;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr = 0;
    int n_done = 0;

    task automatic model_edge();
        bit busy_b, px_b;
        int a;
        edge_n++;
        if (!rst_n) begin
            sw_start = FAR;
            px_e = FAR;
            pend = 1'b0;
            exp_q.delete();
            x_e = '0;
            y_e = '0;
        end else begin
            busy_b = (edge_n - 1 >= sw_start) && (edge_n - 1 <= sw_start + N + LAT - 1);
            px_b   = (edge_n - 1 == px_e);
            if (busy_b || px_b) begin
                if (frame_req) pend = 1'b1;
            end else if (frame_req || pend) begin
                sw_start = edge_n;
                pend = 1'b0;
                for (int i = 0; i < N; i++) exp_q.push_back(ADDR_W'(i));
            end else if (pif.px_req) begin
                px_e  = edge_n;
                pxa_m = pif.px_addr;
                pxd_m = pif.px_data;
                pxw_m = enable && (int'(pif.px_addr) < N);
            end
        end
        b_e   = (edge_n >= sw_start) && (edge_n <= sw_start + N + LAT - 1);
        dn_e  = (edge_n == sw_start + N + LAT);
        ack_e = (edge_n == px_e);
        if (edge_n >= sw_start && edge_n < sw_start + N) begin
            x_e = SCAN_W'((edge_n - sw_start) % W);
            y_e = SCAN_W'((edge_n - sw_start) / W);
        end
        if (edge_n >= sw_start + LAT && edge_n < sw_start + LAT + N && exp_q.size() > 0) begin
            a_e = exp_q.pop_front();
            a   = int'(a_e);
            w_e = enable;
            d_e = DATA_W'((a % W) + (a / W));
        end else if (ack_e) begin
            w_e = pxw_m;
            a_e = pxa_m;
            d_e = pxd_m;
        end else begin
            w_e = 1'b0;
            a_e = '0;
            d_e = '0;
        end
        if (edge_n >= sw_start && edge_n < sw_start + N)           st_e = 1;
        else if (edge_n >= sw_start + N && edge_n <= sw_start + N + LAT - 1) st_e = 2;
        else if (ack_e)                                             st_e = 3;
        else                                                        st_e = 0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        if (fb_wen === 1'b1) n_wr++;
        if (frame_done === 1'b1) n_done++;
        chk("scan_x",     32'(scan_x),     32'(x_e));
        chk("scan_y",     32'(scan_y),     32'(y_e));
        chk("fb_wen",     32'(fb_wen),     32'(w_e));
        chk("fb_addr",    32'(fb_addr),    32'(a_e));
        chk("fb_din",     32'(fb_din),     32'(d_e));
        chk("busy",       32'(busy),       32'(b_e));
        chk("frame_done", 32'(frame_done), 32'(dn_e));
        chk("px_ack",     32'(pif.px_ack), 32'(ack_e));
        chk("state_dbg",  32'(state_dbg),  32'(st_e));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_frame();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
    endtask

    task automatic pixel(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int budget);
        bit got = 1'b0;
        pif.px_req  = 1'b1;
        pif.px_addr = a;
        pif.px_data = d;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (ack_e) got = 1'b1;
        end
        pif.px_req = 1'b0;
        chk("px_grant_in_budget", 32'(got), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0;
        frame_req = 1'b0;
        enable = 1'b1;
        pif.px_req = 1'b0;
        pif.px_addr = '0;
        pif.px_data = '0;
        run(3);
        rst_n = 1'b1;
        run(2);

        // Single sweep: every address once, in order, one frame_done.
        n_wr = 0;
        n_done = 0;
        pulse_frame();
        run(N + LAT + 4);
        chk("sweep1_writes", 32'(n_wr), 32'(N));
        chk("sweep1_done", 32'(n_done), 32'd1);

        // Three requests during one sweep merge into a single extra sweep.
        n_done = 0;
        pulse_frame();
        run(10);
        pulse_frame();
        run(20);
        pulse_frame();
        run(2 * (N + LAT) + 10);
        chk("merged_sweeps_done", 32'(n_done), 32'd2);

        // Enable low for ten write slots mid-sweep.
        n_wr = 0;
        n_done = 0;
        pulse_frame();
        run(LAT + 5);
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(N + 5);
        chk("gated_writes", 32'(n_wr), 32'(N - 10));
        chk("gated_done", 32'(n_done), 32'd1);

        // Pixel writes: in range, just past the end, last pixel, first pixel.
        pixel(ADDR_W'(37), 6'h2A, 4);
        run(1);
        n_wr = 0;
        pixel(ADDR_W'(N), 6'h15, 4);
        chk("oob_pixel_no_write", 32'(n_wr), 32'd0);
        run(1);
        pixel(ADDR_W'(N - 1), 6'h3F, 4);
        run(1);
        enable = 1'b0;
        pixel(ADDR_W'(0), 6'h01, 4);
        enable = 1'b1;
        run(1);

        // Held request is granted every other cycle.
        pif.px_req = 1'b1;
        pif.px_addr = ADDR_W'(5);
        pif.px_data = 6'h0C;
        run(6);
        pif.px_req = 1'b0;
        run(2);

        // Frame and pixel together: sweep wins, pixel acked after frame_done.
        frame_req = 1'b1;
        pif.px_req = 1'b1;
        pif.px_addr = ADDR_W'(9);
        pif.px_data = 6'h33;
        step();
        frame_req = 1'b0;
        pixel(ADDR_W'(9), 6'h33, N + LAT + 8);
        run(2);

        // Reset mid-sweep aborts without frame_done, then restarts at (0,0).
        n_done = 0;
        pulse_frame();
        run(20);
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(LAT + 3);
        chk("abort_no_done", 32'(n_done), 32'd0);
        pulse_frame();
        run(N + LAT + 4);
        chk("restart_done", 32'(n_done), 32'd1);

        // Random mix of frame requests, pixel requests and enable.
        for (int k = 0; k < 600; k++) begin
            frame_req = ($urandom_range(0, 99) < 2);
            enable = ($urandom_range(0, 9) != 0);
            if (!pif.px_req && $urandom_range(0, 3) == 0) begin
                pif.px_req = 1'b1;
                pif.px_addr = ADDR_W'($urandom_range(0, N + 3));
                pif.px_data = DATA_W'($urandom);
            end
            step();
            if (ack_e) pif.px_req = 1'b0;
        end
        frame_req = 1'b0;
        pif.px_req = 1'b0;
        enable = 1'b1;
        run(2 * (N + LAT) + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
